// File: rtl/dispatch_slot_scheduler.sv
// Slot allocator and hazard gate for the per-core dispatch register-address storage.
// Optional build macro: DISPATCH_WAW_CHECK_EN (adds destination-match WAW hazard).
module dispatch_slot_scheduler #(
  parameter int CORE          = 0,
  parameter int ADDRESS_WIDTH = 5,
  parameter int STAGES        = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     disp_valid,
  input  logic [ADDRESS_WIDTH-1:0] disp_rs1,
  input  logic [ADDRESS_WIDTH-1:0] disp_rs2,
  input  logic [ADDRESS_WIDTH-1:0] disp_rW,
  output logic                     disp_ready,
  output logic [STAGES-1:0]        disp_slot,
  input  logic                     ret_valid,
  input  logic [STAGES-1:0]        ret_index,
  input  logic                     flush,
  output logic                     flush_busy,
  output logic                     reg_insert,
  output logic                     reg_delete,
  output logic [ADDRESS_WIDTH-1:0] reg_rs1,
  output logic [ADDRESS_WIDTH-1:0] reg_rs2,
  output logic [ADDRESS_WIDTH-1:0] reg_rW,
  output logic [STAGES-1:0]        reg_indexIns,
  output logic [STAGES-1:0]        reg_indexDel,
  output logic [STAGES:0]          occupancy,
  output logic [15:0]              stall_count,
  output logic                     ret_error,
  output logic                     dbg_state_o
);

  // Handshake: a dispatch transfers on a rising clock edge where disp_valid && disp_ready;
  // disp_ready never depends on disp_valid, and retire/flush have no ready (always taken in IDLE).

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_e;

  state_e                    state_q, state_d;
  logic [STAGES-1:0]         valid_q, valid_d;
  logic [ADDRESS_WIDTH-1:0]  shadow_q [STAGES];
  logic [ADDRESS_WIDTH-1:0]  shadow_d [STAGES];
  logic [STAGES-1:0]         walk_q, walk_d;
  logic [STAGES:0]           occ_q, occ_d;
  logic [15:0]               stall_q, stall_d;
  logic                      err_q, err_d;

  logic                      free_found;
  logic [STAGES-1:0]         free_idx;
  logic                      hazard;
  logic                      ret_hit;
  logic                      walk_hit;

  // Downward scan so the last assignment wins: lowest free index.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = STAGES'(i);
      end
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      if (valid_q[i] && (shadow_q[i] != '0)) begin
        if ((shadow_q[i] == disp_rs1) || (shadow_q[i] == disp_rs2)) hazard = 1'b1;
`ifdef DISPATCH_WAW_CHECK_EN
        if (shadow_q[i] == disp_rW) hazard = 1'b1;
`endif
      end
    end
  end

  // Out-of-range retire indices match no slot and therefore report as errors.
  always_comb begin
    ret_hit  = 1'b0;
    walk_hit = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      if ((ret_index == STAGES'(i)) && valid_q[i]) ret_hit = 1'b1;
      if ((walk_q == STAGES'(i)) && valid_q[i]) walk_hit = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    walk_d       = walk_q;
    valid_d      = valid_q;
    shadow_d     = shadow_q;
    err_d        = err_q;
    stall_d      = stall_q;
    disp_ready   = 1'b0;
    reg_insert   = 1'b0;
    reg_delete   = 1'b0;
    reg_indexIns = free_idx;
    reg_indexDel = ret_index;

    case (state_q)
      IDLE: begin
        disp_ready = !reset && !ret_valid && free_found && !hazard;
        if (ret_valid) begin
          reg_indexIns = ret_index;
          if (ret_hit) begin
            reg_delete = !reset;
            for (int i = 0; i < STAGES; i++) begin
              if (ret_index == STAGES'(i)) begin
                valid_d[i]  = 1'b0;
                shadow_d[i] = '0;
              end
            end
          end else begin
            err_d = 1'b1;
          end
        end else if (disp_valid && disp_ready) begin
          reg_insert = 1'b1;
          for (int i = 0; i < STAGES; i++) begin
            if (free_idx == STAGES'(i)) begin
              valid_d[i]  = 1'b1;
              shadow_d[i] = disp_rW;
            end
          end
        end
        if (flush) begin
          state_d = FLUSH;
          walk_d  = '0;
        end
      end
      FLUSH: begin
        reg_indexDel = walk_q;
        reg_indexIns = walk_q;
        if (walk_hit) begin
          reg_delete = !reset;
          for (int i = 0; i < STAGES; i++) begin
            if (walk_q == STAGES'(i)) begin
              valid_d[i]  = 1'b0;
              shadow_d[i] = '0;
            end
          end
        end
        if (walk_q == STAGES'(STAGES - 1)) begin
          state_d = IDLE;
        end else begin
          walk_d = walk_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (disp_valid && !disp_ready && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ_d = occ_d + {{STAGES{1'b0}}, valid_d[i]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      walk_q  <= '0;
      valid_q <= '0;
      occ_q   <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < STAGES; i++) shadow_q[i] <= '0;
    end else begin
      state_q <= state_d;
      walk_q  <= walk_d;
      valid_q <= valid_d;
      occ_q   <= occ_d;
      stall_q <= stall_d;
      err_q   <= err_d;
      for (int i = 0; i < STAGES; i++) shadow_q[i] <= shadow_d[i];
    end
  end

  assign disp_slot   = free_idx;
  assign reg_rs1     = disp_rs1;
  assign reg_rs2     = disp_rs2;
  assign reg_rW      = disp_rW;
  assign flush_busy  = (state_q == FLUSH);
  assign occupancy   = occ_q;
  assign stall_count = stall_q;
  assign ret_error   = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dispatch_slot_scheduler.sv
// Directed bench for dispatch_slot_scheduler: allocation, hazards, retire, flush, reset.
module tb_dispatch_slot_scheduler;

  localparam int AW = 5;
  localparam int ST = 4;

`ifdef DISPATCH_WAW_CHECK_EN
  localparam logic WAW = 1'b1;
`else
  localparam logic WAW = 1'b0;
`endif

  logic          clock;
  logic          reset;
  logic          disp_valid;
  logic [AW-1:0] disp_rs1, disp_rs2, disp_rW;
  logic          disp_ready;
  logic [ST-1:0] disp_slot;
  logic          ret_valid;
  logic [ST-1:0] ret_index;
  logic          flush;
  logic          flush_busy;
  logic          reg_insert, reg_delete;
  logic [AW-1:0] reg_rs1, reg_rs2, reg_rW;
  logic [ST-1:0] reg_indexIns, reg_indexDel;
  logic [ST:0]   occupancy;
  logic [15:0]   stall_count;
  logic          ret_error;
  logic          dbg_state_o;

  int errors = 0;
  int checks = 0;

  dispatch_slot_scheduler #(.CORE(0), .ADDRESS_WIDTH(AW), .STAGES(ST)) dut (
    .clock(clock), .reset(reset),
    .disp_valid(disp_valid), .disp_rs1(disp_rs1), .disp_rs2(disp_rs2), .disp_rW(disp_rW),
    .disp_ready(disp_ready), .disp_slot(disp_slot),
    .ret_valid(ret_valid), .ret_index(ret_index),
    .flush(flush), .flush_busy(flush_busy),
    .reg_insert(reg_insert), .reg_delete(reg_delete),
    .reg_rs1(reg_rs1), .reg_rs2(reg_rs2), .reg_rW(reg_rW),
    .reg_indexIns(reg_indexIns), .reg_indexDel(reg_indexDel),
    .occupancy(occupancy), .stall_count(stall_count), .ret_error(ret_error),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // drivers: each call starts a new cycle at the falling edge, then settles 1ns
  task automatic cyc(input logic v, input logic [AW-1:0] a, input logic [AW-1:0] b,
                     input logic [AW-1:0] w, input logic rv, input logic [ST-1:0] ri,
                     input logic fl);
    @(negedge clock);
    disp_valid = v; disp_rs1 = a; disp_rs2 = b; disp_rW = w;
    ret_valid = rv; ret_index = ri; flush = fl;
    #1;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    disp_valid = 1'b1; disp_rs1 = '0; disp_rs2 = '0; disp_rW = 5'd1;
    ret_valid = 1'b0; ret_index = '0; flush = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_ready", disp_ready, 0);
    check("rst_insert", reg_insert, 0);
    check("rst_delete", reg_delete, 0);
    check("rst_occ", occupancy, 0);
    check("rst_stall", stall_count, 0);
    check("rst_err", ret_error, 0);
    check("rst_busy", flush_busy, 0);
    @(negedge clock);
    reset = 1'b0;
    disp_valid = 1'b0;

    // four independent dispatches fill slots 0..3
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 5'd0, 5'd0, AW'(k + 1), 1'b0, '0, 1'b0);
      check("fill_ready", disp_ready, 1);
      check("fill_slot", disp_slot, k);
      check("fill_insert", reg_insert, 1);
      check("fill_idx", reg_indexIns, k);
      check("fill_rw", reg_rW, k + 1);
    end

    // cycles A..C: full, fifth request stalls
    cyc(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, '0, 1'b0);
    check("full_occ", occupancy, 4);
    check("full_ready", disp_ready, 0);
    check("full_insert", reg_insert, 0);
    check("stall_a", stall_count, 0);
    cyc(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, '0, 1'b0);
    check("stall_b", stall_count, 1);
    cyc(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, '0, 1'b0);
    check("stall_c", stall_count, 2);

    // D: retire slot 3
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 4'd3, 1'b0);
    check("stall_d", stall_count, 3);
    check("ret3_del", reg_delete, 1);
    check("ret3_idxdel", reg_indexDel, 3);
    check("ret3_idxins", reg_indexIns, 3);
    check("ret3_ins", reg_insert, 0);

    // E: RAW on rs1 against slot 1 (rW=2)
    cyc(1'b1, 5'd2, 5'd0, 5'd6, 1'b0, '0, 1'b0);
    check("e_occ", occupancy, 3);
    check("raw_rs1_ready", disp_ready, 0);

    // F: retire slot 1 with request pending
    cyc(1'b1, 5'd2, 5'd0, 5'd6, 1'b1, 4'd1, 1'b0);
    check("f_stall", stall_count, 4);
    check("ret1_del", reg_delete, 1);
    check("ret1_idxdel", reg_indexDel, 1);
    check("ret1_ready", disp_ready, 0);
    check("ret1_ins", reg_insert, 0);

    // G: freed slot 1 now taken
    cyc(1'b1, 5'd2, 5'd0, 5'd6, 1'b0, '0, 1'b0);
    check("g_occ", occupancy, 2);
    check("g_stall", stall_count, 5);
    check("g_ready", disp_ready, 1);
    check("g_slot", disp_slot, 1);

    // H: RAW on rs2 against slot 2 (rW=3)
    cyc(1'b1, 5'd0, 5'd3, 5'd8, 1'b0, '0, 1'b0);
    check("h_occ", occupancy, 3);
    check("raw_rs2_ready", disp_ready, 0);

    // I: retire slot 2
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 4'd2, 1'b0);
    check("i_stall", stall_count, 6);
    check("ret2_del", reg_delete, 1);
    check("ret2_idxdel", reg_indexDel, 2);

    // J: retire now-invalid slot 2 alongside a dispatch
    cyc(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 4'd2, 1'b0);
    check("bad_del", reg_delete, 0);
    check("bad_ready", disp_ready, 0);
    check("bad_ins", reg_insert, 0);
    check("bad_err_pre", ret_error, 0);
    check("j_occ", occupancy, 2);

    // K: out-of-range retire index
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 4'b1000, 1'b0);
    check("oor_del", reg_delete, 0);
    check("err_set", ret_error, 1);
    check("k_stall", stall_count, 7);

    // L, M: x0 destinations never hazard
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, '0, 1'b0);
    check("err_sticky", ret_error, 1);
    check("x0a_ready", disp_ready, 1);
    check("x0a_slot", disp_slot, 2);
    cyc(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, '0, 1'b0);
    check("x0b_ready", disp_ready, 1);
    check("x0b_slot", disp_slot, 3);

    // N, O: leave slots 0 and 2 valid
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 4'd1, 1'b0);
    check("n_occ", occupancy, 4);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 4'd3, 1'b0);
    check("o_del", reg_delete, 1);

    // P: flush pulse
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, '0, 1'b1);
    check("p_busy", flush_busy, 0);
    check("p_occ", occupancy, 2);
    // Q..T: walk indices 0..3
    cyc(1'b1, 5'd0, 5'd0, 5'd10, 1'b0, '0, 1'b0);
    check("fl0_busy", flush_busy, 1);
    check("fl0_del", reg_delete, 1);
    check("fl0_idx", reg_indexDel, 0);
    check("fl_ready", disp_ready, 0);
    idle_cyc();
    check("fl1_busy", flush_busy, 1);
    check("fl1_del", reg_delete, 0);
    check("fl1_occ", occupancy, 1);
    idle_cyc();
    check("fl2_busy", flush_busy, 1);
    check("fl2_del", reg_delete, 1);
    check("fl2_idxdel", reg_indexDel, 2);
    check("fl2_idxins", reg_indexIns, 2);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, '0, 1'b1);
    check("fl3_busy", flush_busy, 1);
    check("fl3_del", reg_delete, 0);
    check("fl3_occ", occupancy, 0);

    // U: back in IDLE, dispatch resumes
    cyc(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, '0, 1'b0);
    check("u_busy", flush_busy, 0);
    check("u_stall", stall_count, 8);
    check("u_ready", disp_ready, 1);
    check("u_slot", disp_slot, 0);

    // V: same destination as slot 0
    cyc(1'b1, 5'd0, 5'd0, 5'd5, 1'b0, '0, 1'b0);
    check("waw_ready", disp_ready, WAW ? 0 : 1);
    check("waw_ins", reg_insert, WAW ? 0 : 1);
    idle_cyc();
    check("waw_occ", occupancy, WAW ? 1 : 2);
    check("waw_stall", stall_count, WAW ? 9 : 8);

    // reset in the middle of a flush walk
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, '0, 1'b1);
    idle_cyc();
    check("mid_busy0", flush_busy, 1);
    idle_cyc();
    check("mid_busy1", flush_busy, 1);
    @(negedge clock);
    reset = 1'b1;
    disp_valid = 1'b1;
    #1;
    check("mid_rst_busy", flush_busy, 0);
    check("mid_rst_occ", occupancy, 0);
    check("mid_rst_stall", stall_count, 0);
    check("mid_rst_err", ret_error, 0);
    check("mid_rst_ready", disp_ready, 0);
    check("mid_rst_ins", reg_insert, 0);
    check("mid_rst_del", reg_delete, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("post_rst_ready", disp_ready, 1);
    check("post_rst_slot", disp_slot, 0);
    check("post_rst_busy", flush_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dispatch_slot_scheduler.md
# dispatch_slot_scheduler

Controller for the per-core dispatch register-address storage (STAGES slots holding rs1/rs2/rW). It allocates free slots to incoming dispatch requests, blocks requests with register hazards against in-flight slots, and frees slots on retire or flush. It drives the storage's insert and delete ports.

## Interface
- CORE, 0, core identifier; carried for hierarchy naming only, no functional effect
- ADDRESS_WIDTH, 5, register-address width
- STAGES, 4, number of slots; slot indices are binary, STAGES bits wide, values 0..STAGES-1

- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- disp_valid  in  1  dispatch request
- disp_rs1, disp_rs2, disp_rW  in  ADDRESS_WIDTH each  request register addresses
- disp_ready  out  1  request accepted this cycle when high with disp_valid
- disp_slot  out  STAGES  slot granted; valid when disp_valid && disp_ready
- ret_valid  in  1  retire request
- ret_index  in  STAGES  slot to free
- flush  in  1  single-cycle pulse; free all slots
- flush_busy  out  1  flush walk in progress
- reg_insert, reg_delete  out  1 each  storage write strobes
- reg_rs1, reg_rs2, reg_rW  out  ADDRESS_WIDTH each  storage write data
- reg_indexIns, reg_indexDel  out  STAGES each  storage indices
- occupancy  out  STAGES+1 bits  number of valid slots
- stall_count  out  16  saturating count of stalled request cycles
- ret_error  out  1  sticky: retire addressed an invalid slot

## Operation
- State per slot: valid bit, shadow copy of rW. Controller FSM: IDLE, FLUSH.
- Free slot = lowest-index slot with valid=0.
- Hazard (RAW) = any valid slot with rW != 0 and rW equal to disp_rs1 or disp_rs2. Register 0 never hazards.
- disp_ready = (state==IDLE) && !reset && !ret_valid && free slot exists && no hazard.
- Accept (disp_valid && disp_ready): reg_insert=1, reg_indexIns=disp_slot=free slot, reg_rs1/rs2/rW = disp_rs1/rs2/rW; slot valid and shadow rW set at the clock edge.
- Retire (IDLE, ret_valid): if slot ret_index is valid, reg_delete=1, reg_indexDel=reg_indexIns=ret_index, slot cleared at edge. If invalid or ret_index>=STAGES: no delete, ret_error set (sticky until reset).
- Retire has priority: a cycle with ret_valid never accepts a dispatch.
- reg_insert and reg_delete are never high in the same cycle. During delete cycles reg_indexIns mirrors reg_indexDel.
- Stall: disp_valid && !disp_ready increments stall_count, saturating at 16'hFFFF.
- occupancy = popcount of valid bits (registered, updated with them).
- FLUSH: flush in IDLE enters FLUSH next cycle with walk index 0. Each FLUSH cycle visits index i: if valid, reg_delete=1, reg_indexDel=i, valid cleared. After index STAGES-1, return to IDLE. disp_ready=0, ret_valid ignored (no ret_error) while in FLUSH. flush_busy = (state==FLUSH). flush during FLUSH is ignored.
- flush and ret_valid in the same IDLE cycle: the retire is performed, and FLUSH follows.

## Timing
- Insert/delete strobes are combinational in the request cycle. Slot state changes at the following edge.
- A freed slot is allocatable the cycle after retire. A new hazard is visible to the request in the cycle after accept.
- Back-to-back accepts of independent requests: one per cycle until full.
- Flush takes exactly STAGES cycles in FLUSH, then IDLE.
- Reset (any time, including mid-flush): valid bits 0, shadows 0, state IDLE, occupancy 0, stall_count 0, ret_error 0. disp_ready, reg_insert and reg_delete are 0 while reset is high.

## Configuration
- DISPATCH_WAW_CHECK_EN defined: the hazard also includes WAW, i.e. a valid slot with rW != 0 equal to disp_rW stalls the request.
- Undefined: RAW only. Requests with a matching destination are accepted.

## Test plan
- Reset, then 4 independent dispatches (rW=1,2,3,4, sources 0): slots 0,1,2,3 granted on consecutive cycles, occupancy 4. A 5th request stalls and stall_count increments each cycle.
- With slot 1 holding rW=2: request rs1=2 sees disp_ready=0. ret_valid ret_index=1 gives reg_delete=1 and reg_indexDel=1 that cycle. The request is accepted the next cycle into slot 1.
- Request rs1=0, rs2=0, rW=0 while slots hold rW=0: accepted (no x0 hazard).
- ret_valid on invalid slot 2: reg_delete=0, ret_error=1 and stays 1. Simultaneous disp_valid with ret_valid: not accepted.
- Slots 0 and 2 valid, pulse flush: flush_busy for 4 cycles, reg_delete at indices 0 and 2 only, occupancy 0, then dispatch resumes. Assert reset mid-flush: immediate IDLE, all outputs at reset values.
- With DISPATCH_WAW_CHECK_EN: slot holds rW=5, request rW=5 stalls. Without the macro, the same request is accepted.
